sram_arbiter: RTL
=================

# sram_arbiter

Two-master round-robin arbiter and access sequencer for the single-port `sram` macro. It sits between the instruction-fetch port (m0) and the load/store port (m1) of the core and the one shared `sram` instance. It serialises their requests, holds `cs`/`wr`/`addr`/`din` stable for a programmable number of wait cycles, and returns read data with a one-cycle completion pulse.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: word address width; matches `sram`.
- `DATA_WIDTH`, 32: data word width; matches `sram`.
- `WAIT_CYCLES`, 1: cycles `sram_cs` is held per access. Legal range is ≥1; it covers `sram` DELAY_TIME.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `m0_req` / `m1_req`  in  1  request; held until `mX_gnt`.
- `m0_wr` / `m1_wr`  in  1  1 = write, 0 = read.
- `m0_addr` / `m1_addr`  in  ADDR_WIDTH  word address.
- `m0_wdata` / `m1_wdata`  in  DATA_WIDTH  write data.
- `m0_gnt` / `m1_gnt`  out  1  request accepted this cycle; combinational.
- `m0_rvalid` / `m1_rvalid`  out  1  one-cycle completion pulse, for reads and writes.
- `m0_rdata` / `m1_rdata`  out  DATA_WIDTH  read data; valid while `mX_rvalid`.
- `sram_cs`  out  1  chip select to `sram.cs`.
- `sram_wr`  out  1  to `sram.wr`.
- `sram_addr`  out  ADDR_WIDTH  to `sram.addr`.
- `sram_din`  out  DATA_WIDTH  to `sram.din`.
- `sram_dout`  in  DATA_WIDTH  from `sram.dout`.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE → ACCESS:
  - Taken when any `mX_req` = 1.
  - The winner's `gnt` is asserted combinationally in that cycle.
  - The winner's `wr`/`addr`/`wdata` and its index are latched at that edge.
- ACCESS:
  - `sram_cs` = 1; `sram_wr`, `sram_addr` and `sram_din` are driven from the latched values.
  - Wait counter loads WAIT_CYCLES−1 on entry and decrements each cycle.
  - At count 0: `sram_dout` is captured into the winner's `rdata` register (reads only), then the FSM goes to DONE.
- DONE:
  - `sram_cs` = 0 and `sram_wr` = 0.
  - Winner's `rvalid` = 1 for exactly this cycle.
  - Next state is IDLE. No arbitration happens in DONE.
- Arbitration:
  - Only one requesting master: it wins.
  - Both requesting: the master holding the priority pointer wins.
  - After every grant, the pointer moves to the other master.
  - Reset pointer = m0.
- Grant rules:
  - At most one `gnt` per cycle.
  - `gnt` is never asserted outside IDLE.
  - A request dropped before `gnt` is ignored, with no side effects.
- Write completion:
  - `rvalid` pulses.
  - `rdata` holds its previous value.
- `mX_rdata` holds its value until the next read completes for that master.
- `sram_wr` is never 1 while `sram_cs` = 0.
- `sram_addr`/`sram_din` do not change while `sram_cs` = 1.

## Timing
- Grant in cycle T. Then:
  - ACCESS is cycles T+1 … T+WAIT_CYCLES.
  - `rvalid` is at T+WAIT_CYCLES+1.
  - IDLE is at T+WAIT_CYCLES+2; the next grant is possible there.
- Throughput: one access per WAIT_CYCLES+2 cycles. With WAIT_CYCLES=1, that is one access every 3 cycles.
- All `sram_*` outputs and `mX_rvalid`/`mX_rdata` come straight from flops. No glitches on `sram_cs`/`sram_wr`.
- Reset values (while `rst_n` = 0):
  - `sram_cs` = 0, `sram_wr` = 0, `sram_addr` = 0, `sram_din` = 0.
  - `m0_gnt` = `m1_gnt` = 0 and `m0_rvalid` = `m1_rvalid` = 0.
  - `m0_rdata` = `m1_rdata` = 0.
  - State = IDLE, pointer = m0.
- Reset mid-access:
  - `sram_cs` drops immediately (asynchronously).
  - The in-flight transaction is aborted and no `rvalid` is issued.
  - The requester must re-issue.
- Counter width is $clog2(WAIT_CYCLES+1).

## Structure
- Shared package `sram_arb_pkg` holds:
  - State encoding constants IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
  - Master index constants M0=1'b0, M1=1'b1.
- One sub-module, `rr_arb2`:
  - Combinational 2-way round-robin picker.
  - Inputs: `req[1:0]`, `ptr`, `en`.
  - Outputs: `gnt[1:0]`, `win_idx`.
  - The pointer flop lives in `sram_arbiter`.

## Test plan
- Reset with both `req` high, then release reset:
  - All outputs are 0 during reset.
  - m0 is granted in the first cycle after release.
  - With m0 deasserting after its grant, m1 is granted at T+WAIT_CYCLES+2.
- m1 write addr 1 data 11, then m1 write addr 2 data 22; next, m0 read addr 1, then m0 read addr 2:
  - The reads return 11 and then 22.
  - Each read's `rvalid` is exactly WAIT_CYCLES+1 cycles after its `gnt`.
- Both masters hold reads continuously (m0 addr 100, m1 addr 1023) for 8 grants:
  - Grants alternate m0, m1, m0, …
  - No cycle has both `gnt` high.
- WAIT_CYCLES=3, write addr 5 data 0xDEADBEEF:
  - `sram_cs` is high for exactly 3 consecutive cycles, with `addr`/`din` constant.
  - A following read of addr 5 returns 0xDEADBEEF.
- Assert `rst_n` low during the 2nd ACCESS cycle with WAIT_CYCLES=3:
  - `sram_cs` drops with no clock edge.
  - No `rvalid` appears after reset releases.
  - The pointer is back to m0.
- m0 pulses `req` for one cycle while the arbiter is busy (in DONE):
  - No grant and no access are produced.
  - `m0_rdata` is unchanged.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared constants for the two-master SRAM arbiter: FSM state encoding,
// master indices and a small helper for the round-robin pointer.
package sram_arb_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  // Master indices (instruction fetch = M0, load/store = M1)
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // The master that gets priority after idx has been served.
  function automatic logic other_master(input logic idx);
    return (idx == M0) ? M1 : M0;
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker. The priority pointer flop lives
// in the parent; this block only decides who wins in the current cycle.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       win_idx
);

  // Pick the winner: a lone requester always wins, a tie goes to ptr.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    gnt     = 2'b00;
    win_idx = M0;
    if (req == 2'b11) begin
      win_idx = ptr;
    end else begin
      win_idx = req[1];
    end
    if (en) begin
      gnt = ((win_idx == M1) ? 2'b10 : 2'b01) & req;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master round-robin arbiter and access sequencer for the single-port
// sram macro. One access at a time: IDLE (arbitrate) -> ACCESS (hold cs for
// WAIT_CYCLES cycles) -> DONE (completion pulse) -> IDLE.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // master 0: instruction fetch
  input  logic                  m0_req,
  input  logic                  m0_wr,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  // master 1: load/store
  input  logic                  m1_req,
  input  logic                  m1_wr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  // sram macro side
  output logic                  sram_cs,
  output logic                  sram_wr,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ptr_q, ptr_d;
  logic                  win_q, win_d;
  logic                  cs_q, cs_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;

  logic                  arb_en;
  logic [1:0]            gnt;
  logic                  win_idx;

  // Grants are only offered in IDLE, and never while reset is held, since
  // the state flop reads IDLE during reset but nothing may be accepted.
  assign arb_en = (state_q == IDLE) && rst_n;

  rr_arb2 u_rr_arb2 (
    .req     ({m1_req, m0_req}),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .win_idx (win_idx)
  );

  // Next-state logic for the access sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    cs_d       = cs_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    din_d      = din_q;
    rvalid_d   = 2'b00;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;

    case (state_q)
      IDLE: begin
        if (|gnt) begin
          state_d = ACCESS;
          cnt_d   = CNT_LOAD;
          win_d   = win_idx;
          ptr_d   = other_master(win_idx);
          cs_d    = 1'b1;
          wr_d    = (win_idx == M1) ? m1_wr    : m0_wr;
          addr_d  = (win_idx == M1) ? m1_addr  : m0_addr;
          din_d   = (win_idx == M1) ? m1_wdata : m0_wdata;
        end
      end

      ACCESS: begin
        if (cnt_q == '0) begin
          state_d         = DONE;
          cs_d            = 1'b0;
          wr_d            = 1'b0;
          rvalid_d[win_q] = 1'b1;
          // Writes leave the master's read data untouched.
          if (!wr_q) begin
            if (win_q == M1) begin
              m1_rdata_d = sram_dout;
            end else begin
              m0_rdata_d = sram_dout;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cs_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data-path registers are reset too because they drive the
      // macro and master outputs directly, which must read zero during reset.
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= M0;
      win_q      <= M0;
      cs_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      rvalid_q   <= 2'b00;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      cs_q       <= cs_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      rvalid_q   <= rvalid_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // Everything facing the macro or the masters comes straight from flops,
  // except the grants, which must answer in the request cycle.
  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign sram_cs   = cs_q;
  assign sram_wr   = wr_q;
  assign sram_addr = addr_q;
  assign sram_din  = din_q;

endmodule
